// File: rtl/split_fifo_module.sv
// Broadcast splitter: each accepted input token is copied into one FIFO per output channel.
// Optional macro SPLIT_TOKEN_COUNT_EN adds a 32-bit token_count port counting accepted pushes.
module split_fifo_module #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_OUTPUTS = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             entry_data,
  input  logic                              entry_valid,
  output logic                              entry_ready,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] output_data,
  output logic [NUM_OUTPUTS-1:0]            output_valid,
  input  logic [NUM_OUTPUTS-1:0]            output_ready,
  output logic                              show_outputs
`ifdef SPLIT_TOKEN_COUNT_EN
  ,
  output logic [31:0]                       token_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [NUM_OUTPUTS-1:0] full;
  logic                   push;

  // Readiness looks only at registered counts, so a same-cycle pop never frees a full slot.
  assign entry_ready  = ~reset & ~(|full);
  assign push         = entry_valid & entry_ready;
  assign show_outputs = |output_valid;

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_chan
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  pop;

    assign pop             = output_valid[k] & output_ready[k];
    assign full[k]         = (count == CW'(FIFO_DEPTH));
    assign output_valid[k] = (count != '0);
    // Storage is never reset; masking on empty keeps stale contents invisible.
    assign output_data[k*DATA_WIDTH +: DATA_WIDTH] = output_valid[k] ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= entry_data;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef SPLIT_TOKEN_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     token_count <= '0;
    else if (push) token_count <= token_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_split_fifo_module.sv
// Bench for split_fifo_module at default parameters: vector table plus hand sequences,
// data checked against per-channel scoreboard queues.
module tb_split_fifo_module;

  logic        clk;
  logic        reset;
  logic [15:0] entry_data;
  logic        entry_valid;
  logic        entry_ready;
  logic [31:0] output_data;
  logic [1:0]  output_valid;
  logic [1:0]  output_ready;
  logic        show_outputs;
`ifdef SPLIT_TOKEN_COUNT_EN
  logic [31:0] token_count;
`endif

  split_fifo_module #(
    .DATA_WIDTH (16),
    .NUM_OUTPUTS(2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .entry_data  (entry_data),
    .entry_valid (entry_valid),
    .entry_ready (entry_ready),
    .output_data (output_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .show_outputs(show_outputs)
`ifdef SPLIT_TOKEN_COUNT_EN
    ,
    .token_count (token_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [1:0]  ordy;
    logic        er;
    logic [1:0]  ov;
  } vec_t;

  vec_t        tbl [15];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_push = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check before the edge, update the scoreboard for the handshakes.
  task automatic cycle(input logic v, input logic [15:0] d, input logic [1:0] ordy,
                       input logic er, input logic [1:0] ov);
    logic [15:0] exp0;
    logic [15:0] exp1;
    entry_valid  = v;
    entry_data   = d;
    output_ready = ordy;
    @(negedge clk);
    exp0 = '0;
    exp1 = '0;
    if (ov[0]) exp0 = (q0.size() != 0) ? q0[0] : 16'hDEAD;
    if (ov[1]) exp1 = (q1.size() != 0) ? q1[0] : 16'hDEAD;
    chk("entry_ready", {31'd0, entry_ready}, {31'd0, er});
    chk("output_valid", {30'd0, output_valid}, {30'd0, ov});
    chk("show_outputs", {31'd0, show_outputs}, {31'd0, |ov});
    chk("data_ch0", {16'd0, output_data[15:0]}, {16'd0, exp0});
    chk("data_ch1", {16'd0, output_data[31:16]}, {16'd0, exp1});
    if (ov[0] && ordy[0] && q0.size() != 0) void'(q0.pop_front());
    if (ov[1] && ordy[1] && q1.size() != 0) void'(q1.pop_front());
    if (v && er) begin
      q0.push_back(d);
      q1.push_back(d);
      n_push++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input logic er);
    chk("idle_entry_ready", {31'd0, entry_ready}, {31'd0, er});
    chk("idle_output_valid", {30'd0, output_valid}, 32'd0);
    chk("idle_show_outputs", {31'd0, show_outputs}, 32'd0);
    chk("idle_output_data", output_data, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // fan-out, then backpressure with channel 1 stalled, full-with-pop, drain
    tbl[0]  = '{1'b1, 16'h1234, 2'b11, 1'b1, 2'b00};
    tbl[1]  = '{1'b0, 16'h0000, 2'b11, 1'b1, 2'b11};
    tbl[2]  = '{1'b0, 16'h0000, 2'b11, 1'b1, 2'b00};
    tbl[3]  = '{1'b1, 16'h0001, 2'b01, 1'b1, 2'b00};
    tbl[4]  = '{1'b1, 16'h0002, 2'b01, 1'b1, 2'b11};
    tbl[5]  = '{1'b1, 16'h0003, 2'b01, 1'b1, 2'b11};
    tbl[6]  = '{1'b1, 16'h0004, 2'b01, 1'b1, 2'b11};
    tbl[7]  = '{1'b1, 16'h0005, 2'b01, 1'b0, 2'b11};
    tbl[8]  = '{1'b1, 16'h0005, 2'b01, 1'b0, 2'b10};
    tbl[9]  = '{1'b1, 16'h0005, 2'b10, 1'b0, 2'b10};
    tbl[10] = '{1'b1, 16'h0005, 2'b10, 1'b1, 2'b10};
    tbl[11] = '{1'b0, 16'h0000, 2'b11, 1'b1, 2'b11};
    tbl[12] = '{1'b0, 16'h0000, 2'b11, 1'b1, 2'b10};
    tbl[13] = '{1'b0, 16'h0000, 2'b11, 1'b1, 2'b10};
    tbl[14] = '{1'b0, 16'h0000, 2'b11, 1'b1, 2'b00};

    reset        = 1'b1;
    entry_valid  = 1'b0;
    entry_data   = '0;
    output_ready = '0;
    #2;
    check_idle(1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_idle(1'b1);

    for (int i = 0; i < 15; i++)
      cycle(tbl[i].v, tbl[i].d, tbl[i].ordy, tbl[i].er, tbl[i].ov);

    // continuous push/pop across pointer wrap
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 16'h00A0 + 16'(i), 2'b11, 1'b1, (i == 0) ? 2'b00 : 2'b11);
    cycle(1'b0, 16'h0000, 2'b11, 1'b1, 2'b11);
    cycle(1'b0, 16'h0000, 2'b11, 1'b1, 2'b00);

`ifdef SPLIT_TOKEN_COUNT_EN
    chk("token_count", token_count, n_push);
`endif

    // reset with three tokens queued
    cycle(1'b1, 16'h00B1, 2'b00, 1'b1, 2'b00);
    cycle(1'b1, 16'h00B2, 2'b00, 1'b1, 2'b11);
    cycle(1'b1, 16'h00B3, 2'b00, 1'b1, 2'b11);
    entry_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_idle(1'b0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_idle(1'b1);
`ifdef SPLIT_TOKEN_COUNT_EN
    chk("token_count_reset", token_count, 32'd0);
`endif
    cycle(1'b1, 16'h00C1, 2'b11, 1'b1, 2'b00);
    cycle(1'b0, 16'h0000, 2'b11, 1'b1, 2'b11);
    cycle(1'b0, 16'h0000, 2'b11, 1'b1, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
